// File: rtl/serial_tx_scheduler.sv
// Round-robin arbiter sharing one byte serializer among NREQ requesters,
// with a watchdog that abandons a transfer whose end pulse never arrives.
module serial_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data_in,
    output logic [NREQ-1:0]   ack,
    output logic              timeout_err,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic [W-1:0]      ser_a,
    output logic              ser_begin,
    input  logic              ser_end
);

    localparam int WDW = 5;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] grant_id_nxt;
    logic [W-1:0]   ser_a_nxt;
    logic [WDW-1:0] wdog, wdog_nxt;
    logic           terr_nxt;
    logic [IDW-1:0] pick_idx;
    logic           pick_vld;
    logic [IDW-1:0] after_grant;

    // Scan offsets from the far end so the offset closest to ptr wins last.
    always_comb begin : rr_pick
        int             idx;
        logic [IDW-1:0] j;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        j        = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            j = IDW'(idx);
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = j;
            end
        end
    end

    assign after_grant = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_id_nxt = grant_id;
        ser_a_nxt    = ser_a;
        wdog_nxt     = wdog;
        terr_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_id_nxt = pick_idx;
                    ser_a_nxt    = data_in[int'(pick_idx)*W +: W];
                    state_nxt    = LAUNCH;
                end
            end
            LAUNCH: begin
                wdog_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                wdog_nxt = wdog + 1'b1;
                // A late end pulse on the final watchdog cycle still completes.
                if (ser_end) begin
                    state_nxt = DONE;
                end else if (wdog == WDW'(TIMEOUT - 1)) begin
                    terr_nxt  = 1'b1;
                    ptr_nxt   = after_grant;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                ptr_nxt   = after_grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            ser_a       <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_id    <= grant_id_nxt;
            ser_a       <= ser_a_nxt;
            wdog        <= wdog_nxt;
            timeout_err <= terr_nxt;
        end
    end

    assign ser_begin = (state == LAUNCH);
    assign busy      = (state != IDLE);

    always_comb begin
        ack = '0;
        if (state == DONE) ack[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed plus randomized transfers checked against a transaction-level
// round-robin model of the scheduler.
module tb_serial_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 15;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data_in;
    logic [NREQ-1:0]   ack;
    logic              timeout_err;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic [W-1:0]      ser_a;
    logic              ser_begin;
    logic              ser_end;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    serial_tx_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
        .timeout_err(timeout_err), .grant_id(grant_id), .busy(busy),
        .ser_a(ser_a), .ser_begin(ser_begin), .ser_end(ser_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        ser_end = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mptr = 0;
    endtask

    // One transfer: req/data presented in IDLE; end pulse in the WAIT cycle
    // whose watchdog count equals dly (dly >= TIMEOUT never ends it).
    task automatic xfer(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] d,
                        input int dly, input int want);
        int idx;
        logic [NREQ-1:0] one;
        idx = rr_pick(r, mptr);
        req = r;
        data_in = d;
        ser_end = 1'b0;
        @(negedge clk);
        chk("launch_begin", ser_begin, 1);
        chk("launch_busy", busy, 1);
        chk("grant_id", grant_id, idx);
        chk("ser_a", ser_a, d[idx*W +: W]);
        if (want >= 0) chk("grant_directed", grant_id, want);
        req = NREQ'($urandom);
        data_in = {$urandom, $urandom};
        for (int w = 0; w < TIMEOUT; w++) begin
            @(negedge clk);
            if (w == 0 || w == dly) begin
                chk("wait_quiet", {ser_begin, timeout_err, ack}, 0);
                chk("wait_ser_a_held", ser_a, d[idx*W +: W]);
            end
            ser_end = (w == dly);
            if (w == dly) break;
        end
        @(negedge clk);
        ser_end = 1'b0;
        req = '0;
        one = '0;
        one[idx] = 1'b1;
        mptr = (idx + 1) % NREQ;
        if (dly < TIMEOUT) begin
            chk("ack", ack, one);
            chk("ack_no_terr", timeout_err, 0);
            @(negedge clk);
            chk("after_ack_idle", {busy, ack, ser_begin}, 0);
        end else begin
            chk("terr", timeout_err, 1);
            chk("terr_no_ack", ack, 0);
            chk("terr_idle", busy, 0);
            @(negedge clk);
            chk("terr_one_pulse", timeout_err, 0);
        end
    endtask

    initial begin
        logic [NREQ*W-1:0] d;
        logic [NREQ-1:0] r;
        reset = 1'b1;
        req = '0;
        data_in = '0;
        ser_end = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ser_a", ser_a, 0);
        chk("rst_pulses", {ser_begin, timeout_err, ack}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_req", {busy, ser_begin}, 0);

        // single request, ack 10 cycles after grant edge
        xfer(4'b0100, 32'h00A5_0000, 8, 2);

        // fairness from ptr 0
        do_reset();
        for (int k = 0; k < 5; k++) xfer(4'b1111, 32'h4433_2211, $urandom_range(0, 5), k % 4);

        // wrap and priority
        xfer(4'b1000, 32'h7700_0000, 1, 3);
        xfer(4'b1001, 32'h5500_0066, 0, 0);
        xfer(4'b1001, 32'h5500_0066, 2, 3);

        // timeout, then search starts at index 2
        xfer(4'b0010, 32'h0000_BE00, TIMEOUT, 1);
        xfer(4'b0111, 32'h00CC_BBAA, 3, 2);

        // end pulse on the last watchdog cycle wins
        xfer(4'b0001, 32'h0000_0042, TIMEOUT - 1, 0);

        // reset mid-transfer
        req = 4'b0100;
        data_in = 32'h0099_0000;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        req = '0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ser_a", ser_a, 0);
        chk("midrst_grant", grant_id, 0);
        chk("midrst_pulses", {ser_begin, timeout_err, ack}, 0);
        @(negedge clk);
        reset = 1'b0;
        mptr = 0;
        xfer(4'b0001, 32'h0000_00F0, 4, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d = {$urandom, $urandom};
            xfer(r, d, $urandom_range(0, TIMEOUT + 1), -1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_idle", {busy, ser_begin, ack}, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
